// File: rtl/isqrt_iter.sv
// Multi-cycle integer square root, y = floor(sqrt(x)), by restoring digit recurrence.
// Define ISQRT_ITER_RADIX16_EN to retire two recurrence steps per clock (8-cycle latency instead of 16).
module isqrt_iter (
   input  logic        clk,
   input  logic        rst,
   input  logic        x_vld,
   input  logic [31:0] x,
   output logic        y_vld,
   output logic [15:0] y,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   typedef struct packed {
      logic [17:0] rem;
      logic [15:0] root;
   } acc_t;

`ifdef ISQRT_ITER_RADIX16_EN
   localparam logic [3:0] LAST_STEP = 4'd7;
`else
   localparam logic [3:0] LAST_STEP = 4'd15;
`endif

   state_t      state;
   logic [3:0]  cnt;
   logic [17:0] rem;
   logic [15:0] root;
   logic [31:0] xs;

   logic        accept;
   logic [31:0] src_xs;
   logic [31:0] nxt_xs;
   acc_t        src;
   acc_t        nxt;

   // One restoring step: try subtracting {root, 01}; keep the difference only if it is non-negative.
   function automatic acc_t rec_step(input acc_t a, input logic [1:0] bits);
      logic [19:0] lhs;
      logic [19:0] rhs;
      logic        ge;
      acc_t        r;
      lhs    = {a.rem, bits};
      rhs    = {2'b00, a.root, 2'b01};
      ge     = (lhs >= rhs);
      r.root = {a.root[14:0], ge};
      // The kept remainder always fits in 18 bits, so mod-2^18 subtraction is exact.
      r.rem  = ge ? (lhs[17:0] - rhs[17:0]) : lhs[17:0];
      return r;
   endfunction

   assign accept = x_vld && !busy;

   // NOTE: every variable assigned in always_comb gets a default on every path, so no latch is inferred.
   always_comb begin
      src_xs = accept ? x : xs;
      src    = accept ? acc_t'('0) : acc_t'({rem, root});
`ifdef ISQRT_ITER_RADIX16_EN
      nxt    = rec_step(rec_step(src, src_xs[31:30]), src_xs[29:28]);
      nxt_xs = {src_xs[27:0], 4'b0000};
`else
      nxt    = rec_step(src, src_xs[31:30]);
      nxt_xs = {src_xs[29:0], 2'b00};
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         rem   <= '0;
         root  <= '0;
         xs    <= '0;
         y     <= '0;
         y_vld <= 1'b0;
         busy  <= 1'b0;
      end else begin
         y_vld <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  state <= RUN;
                  cnt   <= 4'd1;
                  rem   <= nxt.rem;
                  root  <= nxt.root;
                  xs    <= nxt_xs;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               rem  <= nxt.rem;
               root <= nxt.root;
               xs   <= nxt_xs;
               if (cnt == LAST_STEP) begin
                  state <= DONE;
                  cnt   <= '0;
                  y     <= nxt.root;
                  y_vld <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_isqrt_iter.sv
// Self-checking bench for isqrt_iter: directed boundary/handshake cases plus random operands
// checked against a floor-sqrt reference computed with plain arithmetic.
module tb_isqrt_iter;

`ifdef ISQRT_ITER_RADIX16_EN
   localparam int LAT = 8;
`else
   localparam int LAT = 16;
`endif
   localparam int BOUND = 40;

   logic        clk = 1'b0;
   logic        rst;
   logic        x_vld;
   logic [31:0] x;
   logic        y_vld;
   logic [15:0] y;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;
   int busy_gap = 0;

   isqrt_iter dut (
      .clk   (clk),
      .rst   (rst),
      .x_vld (x_vld),
      .x     (x),
      .y_vld (y_vld),
      .y     (y),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_sqrt(input logic [31:0] v);
      longint r;
      longint xv;
      xv = longint'(v);
      r  = longint'($sqrt(real'(xv)));
      while (r * r > xv) r--;
      while ((r + 1) * (r + 1) <= xv) r++;
      return 32'(r);
   endfunction

   // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] v);
      x     = v;
      x_vld = 1'b1;
      tick();
      x_vld = 1'b0;
      x     = $urandom;
   endtask

   // Entered one cycle after acceptance; returns cycles from acceptance to y_vld.
   task automatic wait_y(output int lat);
      lat = 1;
      while (!y_vld && lat < BOUND) begin
         if (!busy) busy_gap++;
         x = $urandom;
         tick();
         lat++;
      end
   endtask

   task automatic single(input string tag, input logic [31:0] v);
      int lat;
      logic [31:0] exp;
      exp = ref_sqrt(v);
      issue(v);
      wait_y(lat);
      check({tag, "_lat"}, 32'(lat), 32'(LAT));
      check({tag, "_y"}, {16'h0, y}, exp);
      tick();
      check({tag, "_vld_one_cycle"}, {31'h0, y_vld}, 32'h0);
      check({tag, "_idle_busy"}, {31'h0, busy}, 32'h0);
      check({tag, "_y_held"}, {16'h0, y}, exp);
   endtask

   initial begin
      int lat;
      int pulses;
      logic [31:0] cur;
      logic [31:0] nxt;

      rst   = 1'b1;
      x_vld = 1'b0;
      x     = '0;
      tick();
      tick();
      check("rst_y_vld", {31'h0, y_vld}, 32'h0);
      check("rst_y", {16'h0, y}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      rst = 1'b0;
      tick();

      single("x0", 32'd0);
      single("x1", 32'd1);
      single("x15", 32'd15);
      single("x16", 32'd16);
      single("xmax", 32'hFFFF_FFFF);
      single("sq65535", 32'hFFFE_0001);
      single("nsq99", 32'd99);

      // Back-to-back issue in the DONE cycle.
      busy_gap = 0;
      issue(32'd144);
      wait_y(lat);
      check("b2b_lat0", 32'(lat), 32'(LAT));
      check("b2b_y0", {16'h0, y}, 32'd12);
      check("b2b_done_busy", {31'h0, busy}, 32'h0);
      issue(32'd10000);
      check("b2b_busy_after", {31'h0, busy}, 32'h1);
      wait_y(lat);
      check("b2b_lat1", 32'(lat), 32'(LAT));
      check("b2b_y1", {16'h0, y}, 32'd100);
      check("b2b_busy_gap", 32'(busy_gap), 32'h0);
      tick();

      // Request while busy must be ignored.
      issue(32'd81);
      repeat (4) tick();
      check("ign_busy", {31'h0, busy}, 32'h1);
      issue(32'd4);
      lat = 6;
      while (!y_vld && lat < BOUND) begin
         tick();
         lat++;
      end
      check("ign_lat", 32'(lat), 32'(LAT));
      check("ign_y", {16'h0, y}, 32'd9);
      pulses = 0;
      repeat (2 * LAT + 4) begin
         tick();
         if (y_vld) pulses++;
      end
      check("ign_extra_pulses", 32'(pulses), 32'h0);

      // Reset in the middle of a computation.
      issue(32'd400);
      repeat (6) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_y", {16'h0, y}, 32'h0);
      check("mid_rst_busy", {31'h0, busy}, 32'h0);
      pulses = 0;
      repeat (2 * LAT + 4) begin
         tick();
         if (y_vld) pulses++;
      end
      check("mid_rst_pulses", 32'(pulses), 32'h0);
      check("mid_rst_y_hold", {16'h0, y}, 32'h0);
      single("after_rst49", 32'd49);

      // Random operands, issued back-to-back, with x scrambled while busy.
      cur = $urandom;
      issue(cur);
      for (int i = 0; i < 2000; i++) begin
         wait_y(lat);
         check("rnd_lat", 32'(lat), 32'(LAT));
         check("rnd_y", {16'h0, y}, ref_sqrt(cur));
         case (i % 4)
            0:       nxt = $urandom_range(0, 1000);
            1: begin nxt = $urandom_range(0, 65535); nxt = nxt * nxt; end
            default: nxt = $urandom;
         endcase
         cur = nxt;
         issue(cur);
      end
      wait_y(lat);
      check("rnd_last_y", {16'h0, y}, ref_sqrt(cur));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
